// File: rtl/tcp_socket_arbiter.sv
// Round-robin arbiter sharing one SocketManager among NUM_REQ requesters, one op in flight,
// per-op timeout and periodic aging ticks. Optional counters: define TCP_SOCKET_ARB_STATS_EN.
module tcp_socket_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int HDR_W      = 64,
  parameter int SOCKID_W   = 10,
  parameter int AGE_PERIOD = 1000000,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [2*NUM_REQ-1:0]        req_op,
  input  logic [HDR_W*NUM_REQ-1:0]    req_headers,
  input  logic [SOCKID_W*NUM_REQ-1:0] req_sockid,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic                        rsp_hit,
  output logic                        rsp_fail,
  output logic [SOCKID_W-1:0]         rsp_sockid,
  output logic                        mgr_lookup_en,
  output logic [HDR_W-1:0]            mgr_lookup_headers,
  input  logic                        mgr_lookup_done,
  input  logic                        mgr_lookup_hit,
  input  logic [SOCKID_W-1:0]         mgr_lookup_sockid,
  output logic                        mgr_insert_en,
  output logic [HDR_W-1:0]            mgr_insert_headers,
  input  logic                        mgr_insert_done,
  input  logic                        mgr_insert_fail,
  input  logic [SOCKID_W-1:0]         mgr_insert_sockid,
  output logic                        mgr_remove_en,
  output logic [SOCKID_W-1:0]         mgr_remove_sockid,
  input  logic                        mgr_remove_done,
  output logic                        mgr_aging_tick,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [31:0]                 stat_ops,
  output logic [15:0]                 stat_timeouts
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AGE_W = (AGE_PERIOD > 1) ? $clog2(AGE_PERIOD) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_REMOVE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    rr_q;
  logic [IDX_W-1:0]    idx_q;
  logic [1:0]          op_q;
  logic [HDR_W-1:0]    key_q;
  logic [SOCKID_W-1:0] sid_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [NUM_REQ-1:0]  req_ready_q;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                rsp_hit_q;
  logic                rsp_fail_q;
  logic [SOCKID_W-1:0] rsp_sockid_q;
  logic                lookup_en_q;
  logic                insert_en_q;
  logic                remove_en_q;
  logic                tick_q;
  logic                timeout_err_q;
  logic [AGE_W-1:0]    age_cnt_q;
  logic                age_pending_q;

  logic [1:0]          op_arr_s  [NUM_REQ];
  logic [HDR_W-1:0]    hdr_arr_s [NUM_REQ];
  logic [SOCKID_W-1:0] sid_arr_s [NUM_REQ];
  logic [IDX_W-1:0]    grant_idx_s;
  logic                grant_found_s;
  logic [IDX_W-1:0]    rr_next_s;
  logic                done_match_s;
  logic                timeout_evt_s;
  logic                tick_issue_s;
  logic                age_wrap_s;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign op_arr_s[g]  = req_op[2*g +: 2];
    assign hdr_arr_s[g] = req_headers[HDR_W*g +: HDR_W];
    assign sid_arr_s[g] = req_sockid[SOCKID_W*g +: SOCKID_W];
  end

  // Rotating priority search: the smallest offset from rr_q that has a valid request wins
  always_comb begin
    logic [IDX_W-1:0] cand;
    logic             hit;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    cand          = '0;
    hit           = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand          = IDX_W'((int'(rr_q) + k) % NUM_REQ);
      hit           = req_valid[cand];
      grant_idx_s   = hit ? cand : grant_idx_s;
      grant_found_s = grant_found_s | hit;
    end
  end

  assign rr_next_s     = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);
  assign done_match_s  = (op_q == 2'b11) ||
                         ((op_q == OP_LOOKUP) && mgr_lookup_done) ||
                         ((op_q == OP_INSERT) && mgr_insert_done) ||
                         ((op_q == OP_REMOVE) && mgr_remove_done);
  assign timeout_evt_s = (state_q == S_WAIT) && !done_match_s && (to_cnt_q == TO_W'(TIMEOUT - 1));
  assign tick_issue_s  = (state_q == S_IDLE) && age_pending_q;
  assign age_wrap_s    = (age_cnt_q == AGE_W'(AGE_PERIOD - 1));

  // Aging counter; a wrap on the same edge that issues a tick keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_cnt_q     <= '0;
      age_pending_q <= 1'b0;
    end else begin
      age_cnt_q <= age_wrap_s ? '0 : age_cnt_q + AGE_W'(1);
      if (age_wrap_s) begin
        age_pending_q <= 1'b1;
      end else if (tick_issue_s) begin
        age_pending_q <= 1'b0;
      end else begin
        age_pending_q <= age_pending_q;
      end
    end
  end

  // Operation sequencer with registered strobes and response fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      idx_q         <= '0;
      op_q          <= 2'b00;
      key_q         <= '0;
      sid_q         <= '0;
      to_cnt_q      <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_hit_q     <= 1'b0;
      rsp_fail_q    <= 1'b0;
      rsp_sockid_q  <= '0;
      lookup_en_q   <= 1'b0;
      insert_en_q   <= 1'b0;
      remove_en_q   <= 1'b0;
      tick_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      lookup_en_q <= 1'b0;
      insert_en_q <= 1'b0;
      remove_en_q <= 1'b0;
      tick_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick_issue_s) begin
            tick_q <= 1'b1;
          end else if (grant_found_s) begin
            req_ready_q <= NUM_REQ'(1) << grant_idx_s;
            idx_q       <= grant_idx_s;
            op_q        <= op_arr_s[grant_idx_s];
            key_q       <= hdr_arr_s[grant_idx_s];
            sid_q       <= sid_arr_s[grant_idx_s];
            rr_q        <= rr_next_s;
            state_q     <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          case (op_q)
            OP_LOOKUP: lookup_en_q <= 1'b1;
            OP_INSERT: insert_en_q <= 1'b1;
            OP_REMOVE: remove_en_q <= 1'b1;
            default:   lookup_en_q <= 1'b0;
          endcase
          to_cnt_q <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (done_match_s) begin
            rsp_valid_q <= NUM_REQ'(1) << idx_q;
            state_q     <= S_RESP;
            case (op_q)
              OP_LOOKUP: begin
                rsp_hit_q    <= mgr_lookup_hit;
                rsp_fail_q   <= 1'b0;
                rsp_sockid_q <= mgr_lookup_sockid;
              end
              OP_INSERT: begin
                rsp_hit_q    <= 1'b0;
                rsp_fail_q   <= mgr_insert_fail;
                rsp_sockid_q <= mgr_insert_sockid;
              end
              OP_REMOVE: begin
                rsp_hit_q    <= 1'b0;
                rsp_fail_q   <= 1'b0;
                rsp_sockid_q <= '0;
              end
              default: begin
                rsp_hit_q    <= 1'b0;
                rsp_fail_q   <= 1'b1;
                rsp_sockid_q <= '0;
              end
            endcase
          end else if (timeout_evt_s) begin
            rsp_valid_q   <= NUM_REQ'(1) << idx_q;
            rsp_hit_q     <= 1'b0;
            rsp_fail_q    <= 1'b1;
            rsp_sockid_q  <= '0;
            timeout_err_q <= 1'b1;
            state_q       <= S_RESP;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready          = req_ready_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_hit            = rsp_hit_q;
  assign rsp_fail           = rsp_fail_q;
  assign rsp_sockid         = rsp_sockid_q;
  assign mgr_lookup_en      = lookup_en_q;
  assign mgr_insert_en      = insert_en_q;
  assign mgr_remove_en      = remove_en_q;
  assign mgr_lookup_headers = key_q;
  assign mgr_insert_headers = key_q;
  assign mgr_remove_sockid  = sid_q;
  assign mgr_aging_tick     = tick_q;
  assign busy               = (state_q != S_IDLE);
  assign timeout_err        = timeout_err_q;

`ifdef TCP_SOCKET_ARB_STATS_EN
  logic [31:0] stat_ops_q;
  logic [15:0] stat_to_q;

  // Saturating completion and timeout counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= 32'd0;
      stat_to_q  <= 16'd0;
    end else begin
      if ((state_q == S_RESP) && (stat_ops_q != 32'hFFFF_FFFF)) begin
        stat_ops_q <= stat_ops_q + 32'd1;
      end else begin
        stat_ops_q <= stat_ops_q;
      end
      if (timeout_evt_s && (stat_to_q != 16'hFFFF)) begin
        stat_to_q <= stat_to_q + 16'd1;
      end else begin
        stat_to_q <= stat_to_q;
      end
    end
  end

  assign stat_ops      = stat_ops_q;
  assign stat_timeouts = stat_to_q;
`else
  assign stat_ops      = 32'd0;
  assign stat_timeouts = 16'd0;
`endif

endmodule

// File: tb/tb_tcp_socket_arbiter.sv
// Self-checking bench for tcp_socket_arbiter: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_tcp_socket_arbiter;
  localparam int N  = 4;
  localparam int HW = 64;
  localparam int SW = 10;
  localparam int AP = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [2*N-1:0]  req_op;
  logic [HW*N-1:0] req_headers;
  logic [SW*N-1:0] req_sockid;
  logic [N-1:0]    req_ready, rsp_valid;
  logic            rsp_hit, rsp_fail;
  logic [SW-1:0]   rsp_sockid;
  logic            mgr_lookup_en, mgr_insert_en, mgr_remove_en;
  logic [HW-1:0]   mgr_lookup_headers, mgr_insert_headers;
  logic [SW-1:0]   mgr_remove_sockid;
  logic            mgr_lookup_done, mgr_lookup_hit, mgr_insert_done, mgr_insert_fail, mgr_remove_done;
  logic [SW-1:0]   mgr_lookup_sockid, mgr_insert_sockid;
  logic            mgr_aging_tick, busy, timeout_err;
  logic [31:0]     stat_ops;
  logic [15:0]     stat_timeouts;

  int n_checks = 0;
  int n_errors = 0;

  tcp_socket_arbiter #(.NUM_REQ(N), .HDR_W(HW), .SOCKID_W(SW), .AGE_PERIOD(AP), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_headers(req_headers), .req_sockid(req_sockid),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_fail(rsp_fail),
    .rsp_sockid(rsp_sockid),
    .mgr_lookup_en(mgr_lookup_en), .mgr_lookup_headers(mgr_lookup_headers),
    .mgr_lookup_done(mgr_lookup_done), .mgr_lookup_hit(mgr_lookup_hit), .mgr_lookup_sockid(mgr_lookup_sockid),
    .mgr_insert_en(mgr_insert_en), .mgr_insert_headers(mgr_insert_headers),
    .mgr_insert_done(mgr_insert_done), .mgr_insert_fail(mgr_insert_fail), .mgr_insert_sockid(mgr_insert_sockid),
    .mgr_remove_en(mgr_remove_en), .mgr_remove_sockid(mgr_remove_sockid), .mgr_remove_done(mgr_remove_done),
    .mgr_aging_tick(mgr_aging_tick), .busy(busy), .timeout_err(timeout_err),
    .stat_ops(stat_ops), .stat_timeouts(stat_timeouts)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit vbit(input logic [N-1:0] v, input int j);
    return ((v >> j) & N'(1)) != '0;
  endfunction

  // ---------------- behavioural model: one transaction at a time ----------------
  int m_ph, m_rr, m_idx, m_op, m_wait, m_cyc;
  bit m_pend;
  logic [HW-1:0] m_key;
  logic [SW-1:0] m_sid;
  logic [N-1:0]  e_ready, e_rsp;
  bit            e_hit, e_fail, e_len, e_ien, e_ren, e_tick, e_terr;
  logic [SW-1:0] e_sockid;
  int            e_ops, e_tos;

  task automatic model_reset();
    m_ph = 0; m_rr = 0; m_idx = 0; m_op = 0; m_wait = 0; m_cyc = 0; m_pend = 0;
    m_key = '0; m_sid = '0; e_ready = '0; e_rsp = '0; e_hit = 0; e_fail = 0; e_sockid = '0;
    e_len = 0; e_ien = 0; e_ren = 0; e_tick = 0; e_terr = 0; e_ops = 0; e_tos = 0;
  endtask

  task automatic model_finish(input bit h, input bit f, input logic [SW-1:0] s);
    e_rsp = N'(1) << m_idx; e_hit = h; e_fail = f; e_sockid = s; m_ph = 3;
  endtask

  task automatic model_step();
    bit wrap, found;
    int j;
    wrap = (m_cyc % AP) == AP - 1;
    m_cyc++;
    e_ready = '0; e_rsp = '0; e_len = 0; e_ien = 0; e_ren = 0; e_tick = 0;
    case (m_ph)
      0: begin
        if (m_pend) begin
          e_tick = 1; m_pend = 0;
        end else begin
          found = 0;
          for (int off = 0; off < N && !found; off++) begin
            j = (m_rr + off) % N;
            if (vbit(req_valid, j)) begin
              found = 1; m_idx = j; e_ready = N'(1) << j;
              m_op  = int'((req_op >> (2*j)) & 8'd3);
              m_key = HW'(req_headers >> (HW*j));
              m_sid = SW'(req_sockid >> (SW*j));
              m_rr  = (j + 1) % N; m_ph = 1;
            end
          end
        end
      end
      1: begin
        if (m_op == 0) e_len = 1;
        else if (m_op == 1) e_ien = 1;
        else if (m_op == 2) e_ren = 1;
        m_wait = 0; m_ph = 2;
      end
      2: begin
        if (m_op == 3) model_finish(0, 1, '0);
        else if (m_op == 0 && mgr_lookup_done) model_finish(mgr_lookup_hit, 0, mgr_lookup_sockid);
        else if (m_op == 1 && mgr_insert_done) model_finish(0, mgr_insert_fail, mgr_insert_sockid);
        else if (m_op == 2 && mgr_remove_done) model_finish(0, 0, '0);
        else if (m_wait == TO - 1) begin model_finish(0, 1, '0); e_terr = 1; e_tos++; end
        else m_wait++;
      end
      default: begin m_ph = 0; e_ops++; end
    endcase
    if (wrap) m_pend = 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      check("req_ready", req_ready, e_ready);
      check("rsp_valid", rsp_valid, e_rsp);
      check("rsp_hit", rsp_hit, e_hit);
      check("rsp_fail", rsp_fail, e_fail);
      check("rsp_sockid", rsp_sockid, e_sockid);
      check("lookup_en", mgr_lookup_en, e_len);
      check("insert_en", mgr_insert_en, e_ien);
      check("remove_en", mgr_remove_en, e_ren);
      check("lookup_hdr", mgr_lookup_headers, m_key);
      check("insert_hdr", mgr_insert_headers, m_key);
      check("remove_sid", mgr_remove_sockid, m_sid);
      check("aging_tick", mgr_aging_tick, e_tick);
      check("busy", busy, m_ph != 0);
      check("timeout_err", timeout_err, e_terr);
`ifdef TCP_SOCKET_ARB_STATS_EN
      check("stat_ops", stat_ops, e_ops);
      check("stat_timeouts", stat_timeouts, e_tos);
`else
      check("stat_ops", stat_ops, 0);
      check("stat_timeouts", stat_timeouts, 0);
`endif
    end
  end

  // ---------------- SocketManager stand-in ----------------
  int mgr_lat = 1;
  bit mgr_mute = 0;
  bit mgr_hit_cfg = 0;
  bit mgr_fail_cfg = 0;
  logic [SW-1:0] mgr_sid_cfg = '0;
  int inj_req = 0;

  task automatic mgr_raise(input int kind);
    if (kind == 0) begin mgr_lookup_done = 1; mgr_lookup_hit = mgr_hit_cfg; mgr_lookup_sockid = mgr_sid_cfg; end
    else if (kind == 1) begin mgr_insert_done = 1; mgr_insert_fail = mgr_fail_cfg; mgr_insert_sockid = mgr_sid_cfg; end
    else mgr_remove_done = 1;
  endtask

  initial begin
    int pend_cnt, pend_kind, inj_done;
    pend_cnt = 0; pend_kind = 0; inj_done = 0;
    mgr_lookup_done = 0; mgr_lookup_hit = 0; mgr_lookup_sockid = '0;
    mgr_insert_done = 0; mgr_insert_fail = 0; mgr_insert_sockid = '0; mgr_remove_done = 0;
    forever begin
      @(negedge clk);
      mgr_lookup_done = 0; mgr_insert_done = 0; mgr_remove_done = 0;
      if (!rst_n) pend_cnt = 0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) mgr_raise(pend_kind);
      end
      if (inj_req != inj_done) begin inj_done++; mgr_raise(1); end
      if (!mgr_mute && rst_n && (mgr_lookup_en || mgr_insert_en || mgr_remove_en)) begin
        pend_kind = mgr_lookup_en ? 0 : (mgr_insert_en ? 1 : 2);
        if (mgr_lat == 0) mgr_raise(pend_kind);
        else pend_cnt = mgr_lat;
      end
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic wait_ready(input int r);
    bit seen;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = vbit(req_ready, r);
    end
    if (!seen) begin n_checks++; n_errors++; $display("FAIL ready_wait: req_ready[%0d] never seen", r); end
  endtask

  task automatic wait_rsp(output int lat, output int ens);
    lat = 0; ens = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (mgr_lookup_en || mgr_insert_en || mgr_remove_en) ens++;
      if (rsp_valid != '0) begin lat = c; break; end
    end
    if (lat == 0) begin n_checks++; n_errors++; $display("FAIL rsp_wait: no rsp_valid within 60 cycles"); end
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 0;
    for (int c = 0; c < 100 && !idle; c++) begin
      @(negedge clk);
      idle = !busy;
    end
    if (!idle) begin n_checks++; n_errors++; $display("FAIL idle_wait: busy stuck high"); end
  endtask

  initial begin
    int lat, ens, en_cnt, ticks, bad;
    int grants[$];
    int exp_g[5];
    exp_g = '{0, 1, 2, 3, 0};
    req_valid = '0; req_op = '0; req_headers = '0; req_sockid = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_terr", timeout_err, 0);
    rst_n = 1'b1;

    // all four requesters hold remove requests
    mgr_lat = 1;
    req_op = 8'b10_10_10_10;
    req_sockid = {10'd4, 10'd3, 10'd2, 10'd1};
    req_valid = 4'hF;
    en_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (mgr_remove_en) en_cnt++;
      for (int i = 0; i < N; i++) if (vbit(req_ready, i)) grants.push_back(i);
      if (grants.size() >= 5) req_valid = '0;
      if (grants.size() >= 5 && !busy) break;
    end
    check("rr_grant_count", grants.size(), 5);
    for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_grant_order", grants[i], exp_g[i]);
    check("rr_remove_en_count", en_cnt, 5);

    // lookup hit on requester 0, done two clocks after en
    mgr_lat = 2; mgr_hit_cfg = 1; mgr_sid_cfg = 10'd5;
    req_op = 8'b00_00_00_00;
    req_headers[63:0] = 64'h1234_0050_C0A8_0001;
    req_valid = 4'b0001;
    wait_ready(0);
    req_valid = '0;
    wait_rsp(lat, ens);
    check("lookup_latency", lat, 4);
    check("lookup_rsp_valid", rsp_valid, 4'b0001);
    check("lookup_hit", rsp_hit, 1);
    check("lookup_sockid", rsp_sockid, 10'd5);
    check("lookup_key", mgr_lookup_headers, 64'h1234_0050_C0A8_0001);

    // insert on requester 1, immediate done
    mgr_lat = 0; mgr_hit_cfg = 0; mgr_fail_cfg = 0; mgr_sid_cfg = 10'd7;
    req_op[3:2] = 2'b01;
    req_headers[127:64] = 64'h0050_1F90_0A00_0002;
    req_valid = 4'b0010;
    wait_ready(1);
    req_valid = '0;
    wait_rsp(lat, ens);
    check("insert_latency", lat, 2);
    check("insert_rsp_valid", rsp_valid, 4'b0010);
    check("insert_fail", rsp_fail, 0);
    check("insert_sockid", rsp_sockid, 10'd7);

    // illegal op on requester 2
    req_op[5:4] = 2'b11;
    req_valid = 4'b0100;
    wait_ready(2);
    req_valid = '0;
    wait_rsp(lat, ens);
    check("illegal_latency", lat, 2);
    check("illegal_rsp_valid", rsp_valid, 4'b0100);
    check("illegal_fail", rsp_fail, 1);
    check("illegal_no_en", ens, 0);

    // insert with silent manager times out; a late done is dropped
    mgr_mute = 1;
    req_valid = 4'b0010;
    wait_ready(1);
    req_valid = '0;
    wait_rsp(lat, ens);
    check("timeout_latency", lat, TO + 1);
    check("timeout_fail", rsp_fail, 1);
    check("timeout_hit", rsp_hit, 0);
    check("timeout_sockid", rsp_sockid, 0);
    @(negedge clk);
    check("timeout_err_set", timeout_err, 1);
    inj_req++;
    repeat (4) @(negedge clk);
    check("late_done_busy", busy, 0);
    check("timeout_err_sticky", timeout_err, 1);
    mgr_mute = 0;

    // continuous lookups on requester 3 with aging ticks interleaved
    mgr_lat = 3; mgr_hit_cfg = 0; mgr_sid_cfg = 10'd9;
    req_op[7:6] = 2'b00;
    req_headers[255:192] = 64'hAAAA_5555_0102_0304;
    req_valid = 4'b1000;
    ticks = 0; bad = 0;
    repeat (96) begin
      @(negedge clk);
      if (mgr_aging_tick) begin ticks++; if (busy) bad++; end
    end
    req_valid = '0;
    wait_idle();
    check("age_tick_count_in_range", (ticks >= 5) && (ticks <= 7), 1);
    check("age_tick_during_busy", bad, 0);

    // asynchronous reset while waiting on the manager
    mgr_mute = 1;
    req_op[1:0] = 2'b00;
    req_valid = 4'b0001;
    wait_ready(0);
    req_valid = '0;
    repeat (2) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", req_ready, 0);
    check("async_rst_rsp", rsp_valid, 0);
    check("async_rst_terr", timeout_err, 0);
    check("async_rst_hdr", mgr_lookup_headers, 0);
    repeat (2) @(negedge clk);
    mgr_mute = 0; mgr_lat = 1;
    req_op = 8'b00_00_00_00;
    req_valid = 4'b0011;
    rst_n = 1'b1;
    wait_ready(0);
    check("post_reset_first_grant", req_ready, 4'b0001);
    wait_ready(1);
    req_valid = '0;
    wait_idle();
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
